wb_port_arbiter: RTL and testbench

- Writeback-side driver for the register file write port (rd_wren/rd_addr/rd_data).
- Merges two result producers into one registered write per cycle:
  - fixed-latency pipeline results (ALU/jump), which have no backpressure;
  - variable-latency LSU load responses, which use a valid/ready handshake.
- Formats load data (byte/half/word, sign/zero extension), suppresses writes to x0, and issues a stall request when LSU results starve.

---
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port driver: merges fixed-latency pipeline results with buffered LSU loads.
// Optional macro WB_LSU_BYPASS_EN lets a load skip the empty buffer when the port is idle.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_valid_i,
    input  logic [4:0]  pipe_rd_addr_i,
    input  logic [31:0] pipe_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_addr_i,
    input  logic [31:0] lsu_data_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [1:0]  lsu_byte_off_i,
    output logic        rd_wren_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        stall_o,
    output logic        lsu_pending_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [4:0]    r_fifoAddr [FIFO_DEPTH];
    logic [31:0]   r_fifoData [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_starveCnt;
    logic          r_stall;
    logic          r_wren;
    logic [4:0]    r_addr;
    logic [31:0]   r_data;

    logic          w_empty;
    logic          w_full;
    logic          w_lsuXfer;
    logic          w_pipeWin;
    logic          w_pop;
    logic          w_push;
    logic          w_bypass;
    logic [31:0]   w_lsuFmt;
    logic [CW-1:0] w_cntNext;

    // Byte/half selection and extension happen before storage, so the head is write-ready.
    function automatic logic [31:0] formatLoad(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  formatLoad = {{24{b[7]}}, b};
            3'b100:  formatLoad = {24'd0, b};
            3'b001:  formatLoad = {{16{h[15]}}, h};
            3'b101:  formatLoad = {16'd0, h};
            default: formatLoad = word;
        endcase
    endfunction

    assign w_empty   = (r_wrPtr == r_rdPtr);
    assign w_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_lsuXfer = lsu_valid_i && !w_full;
    assign w_pipeWin = pipe_valid_i && (pipe_rd_addr_i != 5'd0);
    assign w_pop     = !w_pipeWin && !w_empty;
    assign w_lsuFmt  = formatLoad(lsu_data_i, lsu_funct3_i, lsu_byte_off_i);

`ifdef WB_LSU_BYPASS_EN
    assign w_bypass  = w_lsuXfer && (lsu_rd_addr_i != 5'd0) && w_empty && !w_pipeWin;
`else
    assign w_bypass  = 1'b0;
`endif

    assign w_push    = w_lsuXfer && (lsu_rd_addr_i != 5'd0) && !w_bypass;

    always_comb begin
        w_cntNext = r_starveCnt;
        if (w_empty || w_pop) begin
            w_cntNext = '0;
        end else if (w_pipeWin && (r_starveCnt != LIMIT)) begin
            w_cntNext = r_starveCnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifoAddr[r_wrPtr[AW-1:0]] <= lsu_rd_addr_i;
            r_fifoData[r_wrPtr[AW-1:0]] <= w_lsuFmt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_starveCnt <= '0;
            r_stall     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_starveCnt <= w_cntNext;
            r_stall     <= (w_cntNext >= LIMIT);
        end
    end

    // Address and data hold their last written values on idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wren <= 1'b0;
            r_addr <= 5'd0;
            r_data <= 32'd0;
        end else if (w_pipeWin) begin
            r_wren <= 1'b1;
            r_addr <= pipe_rd_addr_i;
            r_data <= pipe_data_i;
        end else if (w_bypass) begin
            r_wren <= 1'b1;
            r_addr <= lsu_rd_addr_i;
            r_data <= w_lsuFmt;
        end else if (w_pop) begin
            r_wren <= 1'b1;
            r_addr <= r_fifoAddr[r_rdPtr[AW-1:0]];
            r_data <= r_fifoData[r_rdPtr[AW-1:0]];
        end else begin
            r_wren <= 1'b0;
        end
    end

    assign lsu_ready_o   = !w_full;
    assign lsu_pending_o = !w_empty;
    assign rd_wren_o     = r_wren;
    assign rd_addr_o     = r_addr;
    assign rd_data_o     = r_data;
    assign stall_o       = r_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; expected values are hand-computed.
// Expectations follow WB_LSU_BYPASS_EN when the bench is built with that macro.
module tb_wb_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_valid_i;
    logic [4:0]  pipe_rd_addr_i;
    logic [31:0] pipe_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_addr_i;
    logic [31:0] lsu_data_i;
    logic [2:0]  lsu_funct3_i;
    logic [1:0]  lsu_byte_off_i;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        stall_o;
    logic        lsu_pending_o;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pipe_valid_i   (pipe_valid_i),
        .pipe_rd_addr_i (pipe_rd_addr_i),
        .pipe_data_i    (pipe_data_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_addr_i  (lsu_rd_addr_i),
        .lsu_data_i     (lsu_data_i),
        .lsu_funct3_i   (lsu_funct3_i),
        .lsu_byte_off_i (lsu_byte_off_i),
        .rd_wren_o      (rd_wren_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_o      (rd_data_o),
        .stall_o        (stall_o),
        .lsu_pending_o  (lsu_pending_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle 1ns past it, so checks never race the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                 input logic [2:0] f3, input logic [1:0] off);
        pipe_valid_i   = pv;
        pipe_rd_addr_i = prd;
        pipe_data_i    = pdata;
        lsu_valid_i    = lv;
        lsu_rd_addr_i  = lrd;
        lsu_data_i     = ldata;
        lsu_funct3_i   = f3;
        lsu_byte_off_i = off;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One load on an idle port, then confirm the formatted value reaches rd 7.
    task automatic loadAndCheck(input string tag, input logic [2:0] f3, input logic [1:0] off,
                                input logic [31:0] expData);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h80FF_7F01, f3, off);
        tick();
        idleInputs();
`ifdef WB_LSU_BYPASS_EN
        checkOutput({tag, "_wren"}, rd_wren_o, 1);
        checkOutput({tag, "_addr"}, rd_addr_o, 7);
        checkOutput({tag, "_data"}, rd_data_o, expData);
        tick();
        checkOutput({tag, "_after"}, rd_wren_o, 0);
`else
        checkOutput({tag, "_notyet"}, rd_wren_o, 0);
        checkOutput({tag, "_pending"}, lsu_pending_o, 1);
        tick();
        checkOutput({tag, "_wren"}, rd_wren_o, 1);
        checkOutput({tag, "_addr"}, rd_addr_o, 7);
        checkOutput({tag, "_data"}, rd_data_o, expData);
`endif
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        idleInputs();
        tick();
        tick();
        checkOutput("rst_wren", rd_wren_o, 0);
        checkOutput("rst_addr", rd_addr_o, 0);
        checkOutput("rst_data", rd_data_o, 0);
        checkOutput("rst_stall", stall_o, 0);
        rst_i = 1'b0;
        tick();
        checkOutput("idle_ready", lsu_ready_o, 1);
        checkOutput("idle_pending", lsu_pending_o, 0);
        checkOutput("idle_wren", rd_wren_o, 0);

        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        tick();
        checkOutput("pipe_wren", rd_wren_o, 1);
        checkOutput("pipe_addr", rd_addr_o, 5);
        checkOutput("pipe_data", rd_data_o, 32'h1234);
        idleInputs();
        tick();
        checkOutput("hold_wren", rd_wren_o, 0);
        checkOutput("hold_addr", rd_addr_o, 5);
        checkOutput("hold_data", rd_data_o, 32'h1234);

        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        tick();
        checkOutput("x0pipe_wren", rd_wren_o, 0);
        checkOutput("x0pipe_data", rd_data_o, 32'h1234);
        idleInputs();
        tick();

        loadAndCheck("lb3", 3'b000, 2'd3, 32'hFFFF_FF80);
        loadAndCheck("lbu3", 3'b100, 2'd3, 32'h0000_0080);
        loadAndCheck("lh2", 3'b001, 2'd2, 32'hFFFF_80FF);
        loadAndCheck("lhu1", 3'b101, 2'd1, 32'h0000_7F01);
        loadAndCheck("lb0", 3'b000, 2'd0, 32'h0000_0001);
        loadAndCheck("lw", 3'b010, 2'd0, 32'h80FF_7F01);

        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'hAAAA_5555, 3'b010, 2'd0);
        tick();
        checkOutput("coll_pipe_addr", rd_addr_o, 4);
        checkOutput("coll_pipe_data", rd_data_o, 32'h44);
        idleInputs();
        tick();
        checkOutput("coll_lsu_wren", rd_wren_o, 1);
        checkOutput("coll_lsu_addr", rd_addr_o, 3);
        checkOutput("coll_lsu_data", rd_data_o, 32'hAAAA_5555);
        tick();
        checkOutput("coll_done", rd_wren_o, 0);

        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h9999, 3'b010, 2'd0);
        tick();
        idleInputs();
        checkOutput("x0lsu_pending", lsu_pending_o, 0);
        checkOutput("x0lsu_wren", rd_wren_o, 0);
        tick();
        checkOutput("x0lsu_wren2", rd_wren_o, 0);

        // Two loads fill the buffer behind a continuously valid pipeline.
        applyStimulus(1'b1, 5'd10, 32'h0, 1'b1, 5'd11, 32'h111, 3'b010, 2'd0);
        tick();
        checkOutput("fill0_ready", lsu_ready_o, 1);
        checkOutput("fill0_addr", rd_addr_o, 10);
        applyStimulus(1'b1, 5'd10, 32'h1, 1'b1, 5'd12, 32'h222, 3'b010, 2'd0);
        tick();
        checkOutput("fill1_ready", lsu_ready_o, 0);
        checkOutput("fill1_pending", lsu_pending_o, 1);
        checkOutput("fill1_stall", stall_o, 0);
        applyStimulus(1'b1, 5'd10, 32'h2, 1'b1, 5'd13, 32'h333, 3'b010, 2'd0);
        tick();
        checkOutput("starve2_stall", stall_o, 0);
        applyStimulus(1'b1, 5'd10, 32'h3, 1'b1, 5'd13, 32'h333, 3'b010, 2'd0);
        tick();
        checkOutput("starve3_stall", stall_o, 0);
        applyStimulus(1'b1, 5'd10, 32'h4, 1'b1, 5'd13, 32'h333, 3'b010, 2'd0);
        tick();
        checkOutput("starve4_stall", stall_o, 1);
        checkOutput("starve4_ready", lsu_ready_o, 0);
        applyStimulus(1'b1, 5'd10, 32'h55, 1'b1, 5'd13, 32'h333, 3'b010, 2'd0);
        tick();
        checkOutput("stallwin_addr", rd_addr_o, 10);
        checkOutput("stallwin_data", rd_data_o, 32'h55);
        checkOutput("stallwin_stall", stall_o, 1);
        idleInputs();
        tick();
        checkOutput("drain0_wren", rd_wren_o, 1);
        checkOutput("drain0_addr", rd_addr_o, 11);
        checkOutput("drain0_data", rd_data_o, 32'h111);
        checkOutput("drain0_stall", stall_o, 0);
        checkOutput("drain0_ready", lsu_ready_o, 1);
        tick();
        checkOutput("drain1_addr", rd_addr_o, 12);
        checkOutput("drain1_data", rd_data_o, 32'h222);
        checkOutput("drain1_pending", lsu_pending_o, 0);
        tick();
        checkOutput("drain_done", rd_wren_o, 0);

        // Buffer two loads, then reset and confirm they are dropped.
        applyStimulus(1'b1, 5'd9, 32'h90, 1'b1, 5'd20, 32'h2020, 3'b010, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h91, 1'b1, 5'd21, 32'h2121, 3'b010, 2'd0);
        tick();
        checkOutput("prerst_ready", lsu_ready_o, 0);
        idleInputs();
        rst_i = 1'b1;
        tick();
        checkOutput("midrst_wren", rd_wren_o, 0);
        checkOutput("midrst_addr", rd_addr_o, 0);
        checkOutput("midrst_pending", lsu_pending_o, 0);
        checkOutput("midrst_ready", lsu_ready_o, 1);
        rst_i = 1'b0;
        tick();
        checkOutput("postrst_wren0", rd_wren_o, 0);
        tick();
        checkOutput("postrst_wren1", rd_wren_o, 0);
        checkOutput("postrst_stall", stall_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
